// File: rtl/parqueo_pkg.sv
// Shared state encoding, default sizing and a width helper for the parking gate arbiter.
package parqueo_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    ABIERTO_ENT = 2'b01,
    ABIERTO_SAL = 2'b10,
    CIERRE      = 2'b11
  } estado_t;

  localparam int CAPACIDAD_DEF     = 16;
  localparam int ANCHO_OCUP_DEF    = 5;
  localparam int TIEMPO_MAX_DEF    = 32;
  localparam int TIEMPO_CIERRE_DEF = 4;

  // Bits needed to hold values 0..valor (at least one bit).
  function automatic int ancho_para(input int valor);
    int ancho;
    ancho = $clog2(valor + 1);
    if (ancho < 1) begin
      ancho = 1;
    end else begin
      ancho = ancho;
    end
    return ancho;
  endfunction

endpackage

// File: rtl/contador_ocupacion.sv
// Saturating lot-occupancy up/down counter with a registered full flag.
module contador_ocupacion #(
  parameter int CAPACIDAD  = 16,
  parameter int ANCHO_OCUP = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  output logic [ANCHO_OCUP-1:0] cuenta,
  output logic                  lleno
);

  localparam logic [ANCHO_OCUP-1:0] CAP_V  = ANCHO_OCUP'(CAPACIDAD);
  localparam logic [ANCHO_OCUP-1:0] CERO_V = '0;
  localparam logic [ANCHO_OCUP-1:0] UNO_V  = ANCHO_OCUP'(32'd1);

  logic [ANCHO_OCUP-1:0] cuenta_r;
  logic [ANCHO_OCUP-1:0] cuenta_sig_s;
  logic                  lleno_r;

  // Next count: clamp at both ends even though eligibility should prevent overflow.
  always_comb begin
    cuenta_sig_s = cuenta_r;
    if (inc && !dec && (cuenta_r < CAP_V)) begin
      cuenta_sig_s = cuenta_r + UNO_V;
    end else if (dec && !inc && (cuenta_r != CERO_V)) begin
      cuenta_sig_s = cuenta_r - UNO_V;
    end else begin
      cuenta_sig_s = cuenta_r;
    end
  end

  // Count and full flag register together so they never disagree.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cuenta_r <= CERO_V;
      lleno_r  <= 1'b0;
    end else begin
      cuenta_r <= cuenta_sig_s;
      lleno_r  <= (cuenta_sig_s == CAP_V);
    end
  end

  assign cuenta = cuenta_r;
  assign lleno  = lleno_r;

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes, with occupancy tracking and timeout.
// Define PRIORIDAD_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise exit wins ties.
module parking_gate_arbiter
  import parqueo_pkg::*;
#(
  parameter int CAPACIDAD     = CAPACIDAD_DEF,
  parameter int ANCHO_OCUP    = ANCHO_OCUP_DEF,
  parameter int TIEMPO_MAX    = TIEMPO_MAX_DEF,
  parameter int TIEMPO_CIERRE = TIEMPO_CIERRE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  solicitud_entrada,
  input  logic                  solicitud_salida,
  input  logic                  sensor_paso_vehiculo,
  output logic                  concesion_entrada,
  output logic                  concesion_salida,
  output logic                  abrir_compuerta,
  output logic [ANCHO_OCUP-1:0] ocupacion,
  output logic                  parqueo_lleno,
  output logic                  alarma_timeout
);

  localparam int                ANCHO_T  = ancho_para(TIEMPO_MAX + TIEMPO_CIERRE);
  localparam logic [ANCHO_T-1:0] T_ABORTO = ANCHO_T'(TIEMPO_MAX - 1);
  localparam logic [ANCHO_T-1:0] T_CIERRE = ANCHO_T'(TIEMPO_CIERRE - 1);
  localparam logic [ANCHO_T-1:0] T_SAT    = {ANCHO_T{1'b1}};
  localparam logic [ANCHO_T-1:0] T_UNO    = ANCHO_T'(32'd1);

  estado_t              estado_r;
  estado_t              estado_sig_s;
  logic [ANCHO_T-1:0]   timer_r;
  logic                 visto_r;
  logic                 concesion_ent_r;
  logic                 concesion_sal_r;
  logic                 abrir_r;
  logic                 alarma_r;
  logic                 inc_s;
  logic                 dec_s;
  logic                 alarma_set_s;
  logic                 elig_ent_s;
  logic                 elig_sal_s;
  logic                 concede_s;
  logic                 abierto_s;
  logic                 abierto_sig_s;
  logic [ANCHO_OCUP-1:0] ocupacion_s;
  logic                 lleno_s;

`ifdef PRIORIDAD_ROUND_ROBIN_EN
  logic                 turno_sal_r;
`endif

  contador_ocupacion #(
    .CAPACIDAD (CAPACIDAD),
    .ANCHO_OCUP(ANCHO_OCUP)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .inc   (inc_s),
    .dec   (dec_s),
    .cuenta(ocupacion_s),
    .lleno (lleno_s)
  );

  assign elig_ent_s    = solicitud_entrada && !lleno_s;
  assign elig_sal_s    = solicitud_salida && (ocupacion_s != '0);
  assign abierto_s     = (estado_r == ABIERTO_ENT) || (estado_r == ABIERTO_SAL);
  assign abierto_sig_s = (estado_sig_s == ABIERTO_ENT) || (estado_sig_s == ABIERTO_SAL);
  assign concede_s     = (estado_r == IDLE) && abierto_sig_s;

  // Next-state logic, counter strobes and timeout detection.
  always_comb begin
    estado_sig_s = estado_r;
    inc_s        = 1'b0;
    dec_s        = 1'b0;
    alarma_set_s = 1'b0;
    case (estado_r)
      IDLE: begin
        if (elig_ent_s && elig_sal_s) begin
`ifdef PRIORIDAD_ROUND_ROBIN_EN
          if (turno_sal_r) begin
            estado_sig_s = ABIERTO_SAL;
          end else begin
            estado_sig_s = ABIERTO_ENT;
          end
`else
          estado_sig_s = ABIERTO_SAL;
`endif
        end else if (elig_sal_s) begin
          estado_sig_s = ABIERTO_SAL;
        end else if (elig_ent_s) begin
          estado_sig_s = ABIERTO_ENT;
        end else begin
          estado_sig_s = IDLE;
        end
      end
      ABIERTO_ENT, ABIERTO_SAL: begin
        // A vehicle has passed once the sensor is low again after having been seen.
        if (visto_r && !sensor_paso_vehiculo) begin
          inc_s        = (estado_r == ABIERTO_ENT);
          dec_s        = (estado_r == ABIERTO_SAL);
          estado_sig_s = CIERRE;
        end else if (!visto_r && !sensor_paso_vehiculo && (timer_r >= T_ABORTO)) begin
          alarma_set_s = 1'b1;
          estado_sig_s = CIERRE;
        end else begin
          estado_sig_s = estado_r;
        end
      end
      CIERRE: begin
        if ((timer_r >= T_CIERRE) && !sensor_paso_vehiculo) begin
          estado_sig_s = IDLE;
        end else begin
          estado_sig_s = CIERRE;
        end
      end
      default: begin
        estado_sig_s = IDLE;
      end
    endcase
  end

  // State, timer, vehicle-seen flag and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_r        <= IDLE;
      timer_r         <= '0;
      visto_r         <= 1'b0;
      concesion_ent_r <= 1'b0;
      concesion_sal_r <= 1'b0;
      abrir_r         <= 1'b0;
      alarma_r        <= 1'b0;
    end else begin
      estado_r        <= estado_sig_s;
      concesion_ent_r <= (estado_sig_s == ABIERTO_ENT);
      concesion_sal_r <= (estado_sig_s == ABIERTO_SAL);
      abrir_r         <= abierto_sig_s;
      // Timer restarts on every state change and saturates so a long dwell cannot wrap.
      if (estado_sig_s != estado_r) begin
        timer_r <= '0;
      end else if (timer_r != T_SAT) begin
        timer_r <= timer_r + T_UNO;
      end else begin
        timer_r <= timer_r;
      end
      if (estado_sig_s != estado_r) begin
        visto_r <= 1'b0;
      end else if (abierto_s && sensor_paso_vehiculo) begin
        visto_r <= 1'b1;
      end else begin
        visto_r <= visto_r;
      end
      if (concede_s) begin
        alarma_r <= 1'b0;
      end else if (alarma_set_s) begin
        alarma_r <= 1'b1;
      end else begin
        alarma_r <= alarma_r;
      end
    end
  end

`ifdef PRIORIDAD_ROUND_ROBIN_EN
  // Pointer favours the lane that did not get the most recent grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      turno_sal_r <= 1'b0;
    end else if (concede_s) begin
      turno_sal_r <= (estado_sig_s == ABIERTO_ENT);
    end else begin
      turno_sal_r <= turno_sal_r;
    end
  end
`endif

  assign concesion_entrada = concesion_ent_r;
  assign concesion_salida  = concesion_sal_r;
  assign abrir_compuerta   = abrir_r;
  assign ocupacion         = ocupacion_s;
  assign parqueo_lleno     = lleno_s;
  assign alarma_timeout    = alarma_r;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench: stimulus queues expected output snapshots with their cycle; a monitor checks each output change.
module tb_parking_gate_arbiter;

  localparam int CAP = 2;
  localparam int AO  = 5;
  localparam int TM  = 8;
  localparam int TC  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          se = 1'b0;
  logic          ss = 1'b0;
  logic          sensor = 1'b0;
  logic          concesion_entrada;
  logic          concesion_salida;
  logic          abrir_compuerta;
  logic [AO-1:0] ocupacion;
  logic          parqueo_lleno;
  logic          alarma_timeout;

  parking_gate_arbiter #(
    .CAPACIDAD    (CAP),
    .ANCHO_OCUP   (AO),
    .TIEMPO_MAX   (TM),
    .TIEMPO_CIERRE(TC)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .solicitud_entrada   (se),
    .solicitud_salida    (ss),
    .sensor_paso_vehiculo(sensor),
    .concesion_entrada   (concesion_entrada),
    .concesion_salida    (concesion_salida),
    .abrir_compuerta     (abrir_compuerta),
    .ocupacion           (ocupacion),
    .parqueo_lleno       (parqueo_lleno),
    .alarma_timeout      (alarma_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] vec;
  } esp_t;

  esp_t       cola[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [9:0] prev;

  bit m_ce, m_cs, m_ab, m_al, m_rr;
  int m_oc;
  int idle_at = 0;

  function automatic logic [9:0] modelo_vec();
    logic [AO-1:0] oc;
    oc = AO'(m_oc);
    return {m_ce, m_cs, m_ab, oc, (m_oc == CAP), m_al};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {concesion_entrada, concesion_salida, abrir_compuerta, ocupacion, parqueo_lleno, alarma_timeout};
  endfunction

  task automatic esperar(input int at);
    esp_t e;
    e.at  = at;
    e.vec = modelo_vec();
    cola.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Monitor: every change of the output tuple must match the next queued snapshot and cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [9:0] cur;
      esp_t e;
      cur = dut_vec();
      if (cur !== prev) begin
        n_cmp++;
        if (cola.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
        end else begin
          e = cola.pop_front();
          if (e.vec !== cur || e.at != cyc) begin
            n_err++;
            $display("FAIL outputs cyc=%0d got=%b expected=%b at cyc=%0d", cyc, cur, e.vec, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  // One grant with a vehicle under the gate for n cycles; winner chosen from the spec rules.
  task automatic pase(input bit re, input bit rs, input int n);
    bit ee, es, gana_sal;
    int g;
    se = re;
    ss = rs;
    ee = re && (m_oc < CAP);
    es = rs && (m_oc != 0);
`ifdef PRIORIDAD_ROUND_ROBIN_EN
    gana_sal = es && (!ee || m_rr);
`else
    gana_sal = es;
`endif
    if (!ee && !es) return;
    g = ((cyc > idle_at) ? cyc : idle_at) + 1;
    m_ce = !gana_sal; m_cs = gana_sal; m_ab = 1'b1; m_al = 1'b0; m_rr = !gana_sal;
    esperar(g);
    wait_cyc(g);
    se = 1'b0; ss = 1'b0; sensor = 1'b1;
    repeat (n) @(negedge clock);
    sensor = 1'b0;
    m_ce = 1'b0; m_cs = 1'b0; m_ab = 1'b0;
    m_oc = gana_sal ? m_oc - 1 : m_oc + 1;
    esperar(cyc + 1);
    idle_at = cyc + 1 + TC;
    @(negedge clock);
  endtask

  // Entry grant with no vehicle: aborts after TM open cycles.
  task automatic timeout_ent();
    int g;
    se = 1'b1;
    g = ((cyc > idle_at) ? cyc : idle_at) + 1;
    m_ce = 1'b1; m_cs = 1'b0; m_ab = 1'b1; m_al = 1'b0; m_rr = 1'b1;
    esperar(g);
    wait_cyc(g);
    se = 1'b0;
    m_ce = 1'b0; m_ab = 1'b0; m_al = 1'b1;
    esperar(g + TM);
    idle_at = g + TM + TC;
    wait_cyc(g + TM);
  endtask

  // Reset while the entry lane holds the gate.
  task automatic reset_medio();
    int g;
    se = 1'b1;
    g = ((cyc > idle_at) ? cyc : idle_at) + 1;
    m_ce = 1'b1; m_cs = 1'b0; m_ab = 1'b1; m_al = 1'b0; m_rr = 1'b1;
    esperar(g);
    wait_cyc(g);
    se = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_ce = 1'b0; m_cs = 1'b0; m_ab = 1'b0; m_al = 1'b0; m_oc = 0; m_rr = 1'b0;
    esperar(cyc + 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idle_at = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_ce = 1'b0; m_cs = 1'b0; m_ab = 1'b0; m_al = 1'b0; m_rr = 1'b0; m_oc = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (dut_vec() !== 10'b0) begin
      n_err++;
      $display("FAIL reset_state got=%b expected=%b", dut_vec(), 10'b0);
    end
    prev   = dut_vec();
    mon_en = 1'b1;
    reset  = 1'b1;

    // Empty lot: exit request must be ignored.
    ss = 1'b1;
    repeat (20) @(negedge clock);
    ss = 1'b0;

    pase(1'b1, 1'b0, 3);
    pase(1'b1, 1'b0, 2);

    // Full lot: entry request held, then an exit request is granted.
    se = 1'b1;
    repeat (20) @(negedge clock);
    pase(1'b1, 1'b1, 2);

    timeout_ent();
    pase(1'b1, 1'b0, 20);
    pase(1'b0, 1'b1, 1);

    for (int r = 0; r < 3; r++) begin
      pase(1'b1, 1'b1, 2);
      if (m_oc == 0) pase(1'b1, 1'b0, 1);
      else if (m_oc == CAP) pase(1'b0, 1'b1, 1);
    end

    reset_medio();
    pase(1'b1, 1'b0, 1);

    repeat (10) @(negedge clock);
    mon_en = 1'b0;
    n_cmp++;
    if (cola.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got=%0d expected=0", cola.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Shares one physical barrier gate between the entry lane and the exit lane. Each lane's access controller raises a gate request only after a valid PIN.
- Grants the gate to one lane at a time, holds it open until the vehicle has passed, and enforces a closing dwell before the next grant.
- Tracks lot occupancy and refuses entry when the lot is full.
- Sits between the per-lane access controllers and the gate actuator.

Parameters:
- CAPACIDAD, 16: maximum number of vehicles in the lot.
- ANCHO_OCUP, 5: occupancy counter width; must satisfy 2**ANCHO_OCUP > CAPACIDAD.
- TIEMPO_MAX, 32: cycles the gate may stay open with no vehicle detected before abort.
- TIEMPO_CIERRE, 4: minimum cycles in the closing dwell.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- solicitud_entrada  input  1  entry-lane gate request (level; the entry access controller's gate signal).
- solicitud_salida  input  1  exit-lane gate request (level).
- sensor_paso_vehiculo  input  1  high while a vehicle is under the gate.
- concesion_entrada  output  1  entry lane holds the gate.
- concesion_salida  output  1  exit lane holds the gate.
- abrir_compuerta  output  1  gate actuator open command.
- ocupacion  output  ANCHO_OCUP  current vehicle count.
- parqueo_lleno  output  1  high when ocupacion == CAPACIDAD.
- alarma_timeout  output  1  last grant aborted with no vehicle detected.

Behaviour:
- Reset and outputs
  - All outputs are registered.
  - When reset is low at a clock edge: state = IDLE, all outputs = 0, ocupacion = 0, internal vehicle-seen flag = 0, round-robin pointer = entry.
  - Reset mid-operation closes the gate on the next edge and drops the in-flight grant.
- States: IDLE, ABIERTO_ENT, ABIERTO_SAL, CIERRE.
- IDLE
  - Entry is eligible when solicitud_entrada = 1 and parqueo_lleno = 0.
  - Exit is eligible when solicitud_salida = 1 and ocupacion != 0.
  - One eligible lane: move to that lane's ABIERTO state.
  - Both eligible: resolve by the priority rule (see Optional Feature).
  - Latency: concesion_x and abrir_compuerta go high on the edge after the request is sampled. The timer and vehicle-seen flag clear, and alarma_timeout clears on that same edge.
  - A request that is not eligible is ignored; it does not block the other lane.
- ABIERTO_ENT / ABIERTO_SAL
  - concesion_x = 1 and abrir_compuerta = 1 throughout.
  - The timer increments every cycle.
  - Dropping the request does not revoke the grant.
  - sensor_paso_vehiculo = 1 sets vehicle-seen.
  - Vehicle pass = sensor falls to 0 with vehicle-seen = 1. On the following edge:
    - ocupacion becomes +1 (entry) or -1 (exit);
    - concesion and abrir_compuerta drop;
    - state moves to CIERRE.
  - Timeout: timer reaches TIEMPO_MAX-1 with vehicle-seen = 0 → alarma_timeout = 1, move to CIERRE, ocupacion unchanged.
  - The timeout is suppressed while vehicle-seen = 1. The gate never closes on a vehicle.
- CIERRE
  - abrir_compuerta = 0, no grants, requests ignored.
  - Exit to IDLE after at least TIEMPO_CIERRE cycles and with sensor_paso_vehiculo = 0.
  - A sensor that stays high holds the block in CIERRE indefinitely.
- Counter
  - Saturating: it never exceeds CAPACIDAD and never goes below 0. Eligibility rules guarantee this; the counter also clamps as a backstop.
  - parqueo_lleno updates on the same edge as ocupacion.
- alarma_timeout is sticky until the next grant or reset.

Optional Feature:
- Macro: PRIORIDAD_ROUND_ROBIN_EN.
- Defined: on a simultaneous eligible request the lane indicated by the round-robin pointer wins. The pointer flips to the other lane after each grant.
- Undefined: exit always wins ties (it frees capacity); the pointer logic is absent.

Decomposition:
- Package parqueo_pkg holds:
  - state encoding constants (IDLE=2'b00, ABIERTO_ENT=2'b01, ABIERTO_SAL=2'b10, CIERRE=2'b11);
  - default CAPACIDAD, TIEMPO_MAX and TIEMPO_CIERRE values.
- Sub-module contador_ocupacion: saturating up/down counter with inc, dec and lleno outputs, parameterised by CAPACIDAD and ANCHO_OCUP.

Test Plan (CAPACIDAD=2, TIEMPO_MAX=8, TIEMPO_CIERRE=4):
- Entry pass: reset, then solicitud_entrada=1 → concesion_entrada=1 and abrir_compuerta=1 next cycle. Sensor high 3 cycles then low → gate closes, ocupacion=1, 4+ cycles in CIERRE, back to IDLE.
- Full lot: perform two entries → ocupacion=2, parqueo_lleno=1. Third solicitud_entrada held 20 cycles → no grant. A solicitud_salida is then granted → ocupacion=1, parqueo_lleno=0.
- Empty lot: with ocupacion=0, solicitud_salida=1 for 20 cycles → no grant, no count change.
- Timeout: grant entry, sensor stays 0 → after 8 cycles abrir_compuerta=0, alarma_timeout=1, ocupacion unchanged; the next grant clears alarma_timeout. Separately, hold sensor high for 20 cycles → gate stays open, no timeout.
- Tie: ocupacion=1, both requests asserted in IDLE → with the macro, grants alternate entry/exit/entry across three rounds; without it, exit wins every round.
- Reset mid-grant: assert reset in ABIERTO_ENT → next edge all outputs 0, ocupacion=0, state IDLE.
